// File: rtl/pipeline_pkg.sv
// Shared definitions for the load-use hazard detector: state encoding, the
// zero register, default stall depth and the load-use match function.
package pipeline_pkg;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO                  = 5'd0;
  localparam int unsigned DEFAULT_LOAD_STALL_CYCLES = 32'd1;
  localparam int unsigned DEFAULT_CNT_W             = 32'd3;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt
  );
    return mem_read & (ex_rt != REG_ZERO) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side bundle for the hazard detector. Stall_Count exists only when
// HAZARD_STALL_COUNTER_EN is defined.
interface hazard_detection_unit_if;

  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_Rt;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        Branch_Taken;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        Control_Bubble;
  logic        IF_ID_Flush;
  logic        Stall_Active;
`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] Stall_Count;
`endif

  modport master (
    output ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, Branch_Taken,
    input  PC_Write, IF_ID_Write, Control_Bubble, IF_ID_Flush, Stall_Active
`ifdef HAZARD_STALL_COUNTER_EN
    , input Stall_Count
`endif
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt, Branch_Taken,
    output PC_Write, IF_ID_Write, Control_Bubble, IF_ID_Flush, Stall_Active
`ifdef HAZARD_STALL_COUNTER_EN
    , output Stall_Count
`endif
  );

endinterface

// File: rtl/stall_counter.sv
// Loadable down-counter that tracks the remaining bubbles of a multi-cycle
// load-use stall; last_o flags the final stall cycle.
module stall_counter #(
  parameter int unsigned CNT_W = 32'd3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over load so a taken branch always leaves the counter idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector and stall sequencer. Optional bubble counter output
// is enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_detection_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = DEFAULT_LOAD_STALL_CYCLES,
  parameter int unsigned CNT_W             = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  hazard_detection_unit_if.slave  hz
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_STALL_CYCLES - 32'd1);

  hz_state_e state_q;
  hz_state_e state_d;
  logic      hazard_s;
  logic      cnt_clr_s;
  logic      cnt_load_s;
  logic      cnt_dec_s;
  logic      cnt_last_s;
  logic      pc_write_s;
  logic      ifid_write_s;
  logic      bubble_s;
  logic      flush_s;
  logic      bubble_out_s;

  assign hazard_s = load_use_hazard(hz.ID_EX_MemRead, hz.ID_EX_Rt, hz.IF_ID_Rs, hz.IF_ID_Rt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  stall_counter #(.CNT_W(CNT_W)) u_stall_counter (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (cnt_clr_s),
    .load_i     (cnt_load_s),
    .load_val_i (LOAD_VAL),
    .dec_i      (cnt_dec_s),
    .last_o     (cnt_last_s)
  );

  // A taken branch squashes the dependent instruction, so it beats any stall.
  always_comb begin
    state_d      = state_q;
    cnt_clr_s    = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_dec_s    = 1'b0;
    pc_write_s   = 1'b1;
    ifid_write_s = 1'b1;
    bubble_s     = 1'b0;
    flush_s      = 1'b0;
    if (hz.Branch_Taken) begin
      flush_s   = 1'b1;
      cnt_clr_s = 1'b1;
      state_d   = HZ_RUN;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (hazard_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            bubble_s     = 1'b1;
            if (LOAD_STALL_CYCLES > 32'd1) begin
              cnt_load_s = 1'b1;
              state_d    = HZ_STALL;
            end else begin
              state_d    = HZ_RUN;
            end
          end else begin
            state_d = HZ_RUN;
          end
        end
        HZ_STALL: begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          bubble_s     = 1'b1;
          cnt_dec_s    = 1'b1;
          if (cnt_last_s) begin
            state_d = HZ_RUN;
          end else begin
            state_d = HZ_STALL;
          end
        end
        default: begin
          cnt_clr_s = 1'b1;
          state_d   = HZ_RUN;
        end
      endcase
    end
  end

  // Reset overrides the decode immediately, without waiting for a clock edge.
  always_comb begin
    if (reset) begin
      hz.PC_Write       = 1'b1;
      hz.IF_ID_Write    = 1'b1;
      bubble_out_s      = 1'b0;
      hz.IF_ID_Flush    = 1'b0;
    end else begin
      hz.PC_Write       = pc_write_s;
      hz.IF_ID_Write    = ifid_write_s;
      bubble_out_s      = bubble_s;
      hz.IF_ID_Flush    = flush_s;
    end
  end

  assign hz.Control_Bubble = bubble_out_s;
  assign hz.Stall_Active   = (state_q == HZ_STALL);

`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;

  always_comb begin
    if (bubble_out_s && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.Stall_Count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit with stall depths 1, 3 and 4 side by side.
// Output vectors are packed as {PC_Write, IF_ID_Write, Control_Bubble, IF_ID_Flush, Stall_Active}.
module tb_hazard_detection_unit;

  localparam logic [4:0] RUN_O  = 5'b11000;
  localparam logic [4:0] BUB_O  = 5'b00100;
  localparam logic [4:0] STL_O  = 5'b00101;
  localparam logic [4:0] FLS_O  = 5'b11010;
  localparam logic [4:0] FLSS_O = 5'b11011;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  hazard_detection_unit_if hz1 ();
  hazard_detection_unit_if hz3 ();
  hazard_detection_unit_if hz4 ();

  hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(3)) dut1 (.clk(clk), .reset(reset), .hz(hz1.slave));
  hazard_detection_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(3)) dut3 (.clk(clk), .reset(reset), .hz(hz3.slave));
  hazard_detection_unit #(.LOAD_STALL_CYCLES(4), .CNT_W(3)) dut4 (.clk(clk), .reset(reset), .hz(hz4.slave));

  logic [4:0] o1, o3, o4;
  assign o1 = {hz1.PC_Write, hz1.IF_ID_Write, hz1.Control_Bubble, hz1.IF_ID_Flush, hz1.Stall_Active};
  assign o3 = {hz3.PC_Write, hz3.IF_ID_Write, hz3.Control_Bubble, hz3.IF_ID_Flush, hz3.Stall_Active};
  assign o4 = {hz4.PC_Write, hz4.IF_ID_Write, hz4.Control_Bubble, hz4.IF_ID_Flush, hz4.Stall_Active};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br);
    hz1.ID_EX_MemRead = mr; hz1.ID_EX_Rt = ex_rt; hz1.IF_ID_Rs = rs; hz1.IF_ID_Rt = rt; hz1.Branch_Taken = br;
    hz3.ID_EX_MemRead = mr; hz3.ID_EX_Rt = ex_rt; hz3.IF_ID_Rs = rs; hz3.IF_ID_Rt = rt; hz3.Branch_Taken = br;
    hz4.ID_EX_MemRead = mr; hz4.ID_EX_Rt = ex_rt; hz4.IF_ID_Rs = rs; hz4.IF_ID_Rt = rt; hz4.Branch_Taken = br;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    next_cycle();
    @(negedge clk);
    checks++; if (o1 !== RUN_O) $display("FAIL reset_d1: got %b exp %b", o1, RUN_O); else passed++;
    checks++; if (o3 !== RUN_O) $display("FAIL reset_d3: got %b exp %b", o3, RUN_O); else passed++;
    // A hazard on the inputs must not leak through while reset is held.
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    #1;
    checks++; if (o4 !== RUN_O) $display("FAIL reset_hz_d4: got %b exp %b", o4, RUN_O); else passed++;
    checks++; if (o1 !== RUN_O) $display("FAIL reset_hz_d1: got %b exp %b", o1, RUN_O); else passed++;
`ifdef HAZARD_STALL_COUNTER_EN
    checks++; if (hz3.Stall_Count !== 32'd0) $display("FAIL reset_cnt: got %0d exp 0", hz3.Stall_Count); else passed++;
`endif
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_hazard();
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (o1 !== BUB_O) $display("FAIL single_c0_d1: got %b exp %b", o1, BUB_O); else passed++;
    checks++; if (o3 !== BUB_O) $display("FAIL single_c0_d3: got %b exp %b", o3, BUB_O); else passed++;
    next_cycle();
    drive(1'b0, 5'd0, 5'd8, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (o1 !== RUN_O) $display("FAIL single_c1_d1: got %b exp %b", o1, RUN_O); else passed++;
    checks++; if (o3 !== STL_O) $display("FAIL single_c1_d3: got %b exp %b", o3, STL_O); else passed++;
    next_cycle();
    idle(6);
  endtask

  task automatic test_no_hazard();
    logic [16:0] pats [3];
    pats[0] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b0};
    pats[1] = {1'b0, 5'd8, 5'd8, 5'd8, 1'b0};
    pats[2] = {1'b1, 5'd8, 5'd9, 5'd9, 1'b0};
    for (int p = 0; p < 3; p++) begin
      drive(pats[p][16], pats[p][15:11], pats[p][10:6], pats[p][5:1], pats[p][0]);
      @(negedge clk);
      checks++; if (o1 !== RUN_O) $display("FAIL nohz%0d_d1: got %b exp %b", p, o1, RUN_O); else passed++;
      checks++; if (o3 !== RUN_O) $display("FAIL nohz%0d_d3: got %b exp %b", p, o3, RUN_O); else passed++;
      checks++; if (o4 !== RUN_O) $display("FAIL nohz%0d_d4: got %b exp %b", p, o4, RUN_O); else passed++;
      next_cycle();
    end
    idle(2);
  endtask

  // Hazard is held through the stall: STALL must not re-trigger on it.
  task automatic test_multi_stall();
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
    @(negedge clk);
    checks++; if (o3 !== BUB_O) $display("FAIL multi_c0_d3: got %b exp %b", o3, BUB_O); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== STL_O) $display("FAIL multi_c1_d3: got %b exp %b", o3, STL_O); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (o3 !== STL_O) $display("FAIL multi_c2_d3: got %b exp %b", o3, STL_O); else passed++;
    next_cycle();
    drive(1'b0, 5'd0, 5'd3, 5'd5, 1'b0);
    @(negedge clk);
    checks++; if (o3 !== RUN_O) $display("FAIL multi_c3_d3: got %b exp %b", o3, RUN_O); else passed++;
    checks++; if (o4 !== STL_O) $display("FAIL multi_c3_d4: got %b exp %b", o4, STL_O); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (o4 !== RUN_O) $display("FAIL multi_c4_d4: got %b exp %b", o4, RUN_O); else passed++;
    next_cycle();
    idle(4);
  endtask

  task automatic test_branch_in_stall();
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
    @(negedge clk);
    checks++; if (o3 !== BUB_O) $display("FAIL brstall_c0_d3: got %b exp %b", o3, BUB_O); else passed++;
    next_cycle();
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b1);
    @(negedge clk);
    checks++; if (o3 !== FLSS_O) $display("FAIL brstall_c1_d3: got %b exp %b", o3, FLSS_O); else passed++;
    checks++; if (o4 !== FLSS_O) $display("FAIL brstall_c1_d4: got %b exp %b", o4, FLSS_O); else passed++;
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (o3 !== RUN_O) $display("FAIL brstall_c2_d3: got %b exp %b", o3, RUN_O); else passed++;
    checks++; if (o4 !== RUN_O) $display("FAIL brstall_c2_d4: got %b exp %b", o4, RUN_O); else passed++;
    next_cycle();
    idle(2);
  endtask

  task automatic test_branch_with_hazard();
    drive(1'b1, 5'd7, 5'd7, 5'd7, 1'b1);
    @(negedge clk);
    checks++; if (o1 !== FLS_O) $display("FAIL brhz_c0_d1: got %b exp %b", o1, FLS_O); else passed++;
    checks++; if (o3 !== FLS_O) $display("FAIL brhz_c0_d3: got %b exp %b", o3, FLS_O); else passed++;
    checks++; if (o4 !== FLS_O) $display("FAIL brhz_c0_d4: got %b exp %b", o4, FLS_O); else passed++;
    next_cycle();
    drive(1'b0, 5'd0, 5'd7, 5'd7, 1'b0);
    @(negedge clk);
    checks++; if (o3 !== RUN_O) $display("FAIL brhz_c1_d3: got %b exp %b", o3, RUN_O); else passed++;
    checks++; if (o4 !== RUN_O) $display("FAIL brhz_c1_d4: got %b exp %b", o4, RUN_O); else passed++;
    next_cycle();
    idle(2);
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd12, 5'd12, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (o4 !== BUB_O) $display("FAIL rstmid_c0_d4: got %b exp %b", o4, BUB_O); else passed++;
    next_cycle();
    @(negedge clk);
    checks++; if (o4 !== STL_O) $display("FAIL rstmid_c1_d4: got %b exp %b", o4, STL_O); else passed++;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (o4 !== RUN_O) $display("FAIL rstmid_async_d4: got %b exp %b", o4, RUN_O); else passed++;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    reset = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++; if (o4 !== RUN_O) $display("FAIL rstmid_after_d4: got %b exp %b", o4, RUN_O); else passed++;
`ifdef HAZARD_STALL_COUNTER_EN
    checks++; if (hz3.Stall_Count !== 32'd0) $display("FAIL rstmid_cnt_d3: got %0d exp 0", hz3.Stall_Count); else passed++;
    checks++; if (hz4.Stall_Count !== 32'd0) $display("FAIL rstmid_cnt_d4: got %0d exp 0", hz4.Stall_Count); else passed++;
`endif
    next_cycle();
  endtask

  task automatic test_counter_after_reset();
    test_multi_stall();
`ifdef HAZARD_STALL_COUNTER_EN
    checks++; if (hz3.Stall_Count !== 32'd3) $display("FAIL cnt_d3: got %0d exp 3", hz3.Stall_Count); else passed++;
    checks++; if (hz4.Stall_Count !== 32'd4) $display("FAIL cnt_d4: got %0d exp 4", hz4.Stall_Count); else passed++;
    checks++; if (hz1.Stall_Count !== 32'd3) $display("FAIL cnt_d1: got %0d exp 3", hz1.Stall_Count); else passed++;
`endif
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_single_hazard();
    test_no_hazard();
    test_multi_stall();
    test_branch_in_stall();
    test_branch_with_hazard();
    test_reset_mid_stall();
    test_counter_after_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
